udp_tx_scheduler: RTL and testbench

Shares the single UDP byte-stream transmit path between `N_REQ` payload sources. Arbitrates pending datagrams round-robin, emits the 8-byte UDP header from the winner's latched ports and length, then passes the winner's payload bytes through under a valid/ready handshake. Sits between the application payload sources and the downstream IP/MAC framing stage.

---
 rtl/udp_pkg.sv | 25 ++
 rtl/udp_tx_scheduler_if.sv | 37 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/udp_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_udp_tx_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit path: header length, scheduler
// state encoding and the index of each byte within the 8-byte UDP header.
package udp_pkg;

  localparam int UDP_HDR_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_GAP
  } state_t;

  typedef logic [2:0] hdr_idx_t;

  localparam hdr_idx_t HDR_SRC_HI  = 3'd0;
  localparam hdr_idx_t HDR_SRC_LO  = 3'd1;
  localparam hdr_idx_t HDR_DST_HI  = 3'd2;
  localparam hdr_idx_t HDR_DST_LO  = 3'd3;
  localparam hdr_idx_t HDR_LEN_HI  = 3'd4;
  localparam hdr_idx_t HDR_LEN_LO  = 3'd5;
  localparam hdr_idx_t HDR_CSUM_HI = 3'd6;
  localparam hdr_idx_t HDR_CSUM_LO = 3'd7;

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// Bundle of requester-side and UDP byte-stream signals of udp_tx_scheduler.
//   req/req_src_port/req_dst_port/req_len : datagram requests, slice i per source
//   in_data/in_valid/in_ready             : payload byte streams, slice i per source
//   grant/done/err_len/busy               : arbitration status
//   udp_data/udp_valid/udp_last/udp_ready : merged output byte stream
// slave  = the scheduler side, master = sources plus downstream sink.
interface udp_tx_scheduler_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_src_port;
  logic [16*N_REQ-1:0] req_dst_port;
  logic [16*N_REQ-1:0] req_len;
  logic [8*N_REQ-1:0]  in_data;
  logic [N_REQ-1:0]    in_valid;
  logic [N_REQ-1:0]    in_ready;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic                err_len;
  logic [7:0]          udp_data;
  logic                udp_valid;
  logic                udp_last;
  logic                udp_ready;
  logic                busy;

  modport slave (
    input  req, req_src_port, req_dst_port, req_len, in_data, in_valid, udp_ready,
    output in_ready, grant, done, err_len, udp_data, udp_valid, udp_last, busy
  );

  modport master (
    output req, req_src_port, req_dst_port, req_len, in_data, in_valid, udp_ready,
    input  in_ready, grant, done, err_len, udp_data, udp_valid, udp_last, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : index searched first; search wraps through N_REQ-1 back to 0
//   gnt   : one-hot winner (0 when no request)
//   valid : any request present
//   idx   : binary index of the winner
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int PTR_W = $clog2(N_REQ);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = (32'(ptr) + off) % N_REQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = PTR_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP byte-stream transmit path between N_REQ payload sources.
// Picks a pending datagram round-robin, emits the 8-byte UDP header from the
// winner's latched ports/length, then passes its payload bytes straight
// through, and inserts IFG_CYCLES idle cycles after each datagram.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester, payload and output stream signals (slave side)
module udp_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int MAX_PAYLOAD = 1472,
  parameter int IFG_CYCLES  = 2
) (
  input logic               clk,
  input logic               rst,
  udp_tx_scheduler_if.slave bus
);

  import udp_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win_idx;
  logic [15:0]      src_r;
  logic [15:0]      dst_r;
  logic [15:0]      len_r;
  logic [15:0]      pay_cnt;
  hdr_idx_t         hdr_idx;
  logic [3:0]       gap_cnt;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic             err_r;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_valid;
  logic [PTR_W-1:0] arb_idx;
  logic [15:0]      sel_len;
  logic             len_bad;
  logic [15:0]      udp_len;
  logic             pay_fire;
  logic             pay_last;

  // A requester keeps req high through its done pulse; masking it here stops
  // the same datagram from being arbitrated a second time in that cycle.
  assign arb_req = bus.req & ~done_r;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign sel_len  = bus.req_len[int'(arb_idx)*16 +: 16];
  assign len_bad  = (sel_len == 16'd0) || (sel_len > 16'(MAX_PAYLOAD));
  assign udp_len  = len_r + 16'(UDP_HDR_LEN);
  assign pay_fire = (state == ST_PAYLOAD) && bus.in_valid[win_idx] && bus.udp_ready;
  assign pay_last = pay_fire && (pay_cnt == len_r - 16'd1);

  always_comb begin
    bus.udp_data  = '0;
    bus.udp_valid = 1'b0;
    bus.udp_last  = 1'b0;
    bus.in_ready  = '0;
    case (state)
      ST_HEADER: begin
        bus.udp_valid = 1'b1;
        case (hdr_idx)
          HDR_SRC_HI:  bus.udp_data = src_r[15:8];
          HDR_SRC_LO:  bus.udp_data = src_r[7:0];
          HDR_DST_HI:  bus.udp_data = dst_r[15:8];
          HDR_DST_LO:  bus.udp_data = dst_r[7:0];
          HDR_LEN_HI:  bus.udp_data = udp_len[15:8];
          HDR_LEN_LO:  bus.udp_data = udp_len[7:0];
          HDR_CSUM_HI: bus.udp_data = 8'h00;
          HDR_CSUM_LO: bus.udp_data = 8'h00;
          default:     bus.udp_data = 8'h00;
        endcase
      end
      ST_PAYLOAD: begin
        bus.udp_data          = bus.in_data[int'(win_idx)*8 +: 8];
        bus.udp_valid         = bus.in_valid[win_idx];
        bus.udp_last          = (pay_cnt == len_r - 16'd1);
        bus.in_ready[win_idx] = bus.udp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      win_idx <= '0;
      src_r   <= '0;
      dst_r   <= '0;
      len_r   <= '0;
      pay_cnt <= '0;
      hdr_idx <= '0;
      gap_cnt <= '0;
      grant_r <= '0;
      done_r  <= '0;
      err_r   <= 1'b0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            rr_ptr <= (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
            if (len_bad) begin
              done_r <= arb_gnt;
              err_r  <= 1'b1;
            end else begin
              grant_r <= arb_gnt;
              win_idx <= arb_idx;
              src_r   <= bus.req_src_port[int'(arb_idx)*16 +: 16];
              dst_r   <= bus.req_dst_port[int'(arb_idx)*16 +: 16];
              len_r   <= sel_len;
              hdr_idx <= '0;
              pay_cnt <= '0;
              state   <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (bus.udp_ready) begin
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == HDR_CSUM_LO) state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (pay_fire) begin
            pay_cnt <= pay_cnt + 16'd1;
            if (pay_last) begin
              done_r  <= grant_r;
              grant_r <= '0;
              gap_cnt <= '0;
              state   <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == 4'(IFG_CYCLES - 1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.done    = done_r;
  assign bus.err_len = err_r;
  assign bus.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed self-checking bench for udp_tx_scheduler (N_REQ=4, IFG_CYCLES=2).
module tb_udp_tx_scheduler;

  logic clk;
  logic rst;

  udp_tx_scheduler_if #(.N_REQ(4)) bus ();

  udp_tx_scheduler #(
    .N_REQ       (4),
    .MAX_PAYLOAD (1472),
    .IFG_CYCLES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks;
  int         errors;
  int         cyc;
  int         pay_idx [4];
  int         req_left[4];
  bit         acc_pay;
  int         acc_r;
  logic [7:0] cap[$];
  bit         cap_last[$];
  logic [7:0] exp_b[$];
  bit         exp_l[$];
  logic [3:0] grant_q[$];
  logic [3:0] done_q[$];
  bit         err_q[$];
  int         gap_q[$];
  int         zero_run;
  bit         seen_valid;
  logic [3:0] prev_grant;
  bit         stall_prev;
  logic [7:0] prev_data;
  int         dg_bytes;
  int         hold_cnt;
  bit         ready_mode;
  bit         valid_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int r, input int k);
    return 8'(r * 64 + k * 5 + 7);
  endfunction

  function automatic logic [23:0] out_vec();
    return {bus.grant, bus.done, bus.err_len, bus.udp_valid, bus.udp_last,
            bus.in_ready, bus.busy, bus.udp_data};
  endfunction

  task automatic clear_mon();
    for (int r = 0; r < 4; r++) pay_idx[r] = 0;
    acc_pay = 0; acc_r = 0;
    cap.delete(); cap_last.delete(); exp_b.delete(); exp_l.delete();
    grant_q.delete(); done_q.delete(); err_q.delete(); gap_q.delete();
    zero_run = 0; seen_valid = 0; prev_grant = '0; stall_prev = 0;
    prev_data = '0; dg_bytes = 0; hold_cnt = 0;
  endtask

  // One clock: apply source/sink behaviour after the edge, then observe.
  task automatic step();
    @(posedge clk);
    if (acc_pay) pay_idx[acc_r] = pay_idx[acc_r] + 1;
    acc_pay = 0;
    #1;
    cyc++;
    bus.udp_ready = !(ready_mode && (cyc % 2 == 1));
    for (int r = 0; r < 4; r++) begin
      bus.in_valid[r]       = bus.req[r] && !(valid_mode && (cyc % 3 == 0));
      bus.in_data[r*8 +: 8] = pay_byte(r, pay_idx[r]);
    end
    #1;
    if (stall_prev) begin
      hold_cnt++;
      check("hdr_hold", 32'({bus.udp_valid, bus.udp_data}), 32'({1'b1, prev_data}));
    end
    if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
      grant_q.push_back(bus.grant);
      dg_bytes = 0;
    end
    prev_grant = bus.grant;
    stall_prev = bus.udp_valid && !bus.udp_ready && (dg_bytes < 8) && (bus.grant != 4'b0);
    prev_data  = bus.udp_data;
    if (bus.udp_valid && bus.udp_ready) begin
      cap.push_back(bus.udp_data);
      cap_last.push_back(bus.udp_last);
      dg_bytes++;
    end
    if (bus.udp_valid) begin
      if (seen_valid && zero_run > 0) gap_q.push_back(zero_run);
      zero_run   = 0;
      seen_valid = 1;
    end else begin
      zero_run++;
    end
    for (int r = 0; r < 4; r++)
      if (bus.in_ready[r] && bus.in_valid[r]) begin
        acc_pay = 1;
        acc_r   = r;
      end
    if (bus.done != 4'b0) begin
      done_q.push_back(bus.done);
      err_q.push_back(bus.err_len);
      for (int r = 0; r < 4; r++)
        if (bus.done[r]) begin
          pay_idx[r] = 0;
          if (req_left[r] > 0) req_left[r]--;
          if (req_left[r] == 0) bus.req[r] = 1'b0;
        end
    end
  endtask

  task automatic set_req(input int r, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input int n);
    bus.req_src_port[r*16 +: 16] = s;
    bus.req_dst_port[r*16 +: 16] = d;
    bus.req_len[r*16 +: 16]      = l;
    req_left[r]                  = n;
    bus.req[r]                   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    for (int r = 0; r < 4; r++) req_left[r] = 0;
    step();
    step();
    rst = 1'b0;
    ready_mode = 0;
    valid_mode = 0;
    clear_mon();
  endtask

  task automatic run_done(input string tag, input int n, input int budget);
    int target;
    int left;
    target = done_q.size() + n;
    left   = budget;
    while (done_q.size() < target && left > 0) begin
      step();
      left--;
    end
    check({tag, "_done_count"}, 32'(done_q.size()), 32'(target));
  endtask

  task automatic expect_dgram(input int r, input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] l);
    logic [15:0] tl;
    tl = l + 16'd8;
    exp_b.push_back(s[15:8]);  exp_b.push_back(s[7:0]);
    exp_b.push_back(d[15:8]);  exp_b.push_back(d[7:0]);
    exp_b.push_back(tl[15:8]); exp_b.push_back(tl[7:0]);
    exp_b.push_back(8'h00);    exp_b.push_back(8'h00);
    for (int i = 0; i < 8; i++) exp_l.push_back(1'b0);
    for (int k = 0; k < int'(l); k++) begin
      exp_b.push_back(pay_byte(r, k));
      exp_l.push_back(k == int'(l) - 1);
    end
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_stream_len"}, 32'(cap.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < cap.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_b[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(cap_last[i]), 32'(exp_l[i]));
    end
  endtask

  logic [7:0] hdr1[8];
  int         lasts;
  int         left;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    bus.req = '0; bus.req_src_port = '0; bus.req_dst_port = '0; bus.req_len = '0;
    bus.in_data = '0; bus.in_valid = '0; bus.udp_ready = 1'b0;
    ready_mode = 0; valid_mode = 0;
    for (int r = 0; r < 4; r++) req_left[r] = 0;
    clear_mon();

    // Reset state
    step();
    step();
    check("rst_outputs", 32'(out_vec()), 32'h0);
    rst = 1'b0;
    clear_mon();

    // T1: single datagram, src 5000 dst 5001 len 11
    set_req(0, 16'd5000, 16'd5001, 16'd11, 1);
    step();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_first_byte", 32'({bus.udp_valid, bus.udp_data}), 32'h113);
    check("t1_busy", 32'(bus.busy), 32'h1);
    run_done("t1", 1, 200);
    hdr1 = '{8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h13, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) check($sformatf("t1_hdr%0d", i), 32'(cap[i]), 32'(hdr1[i]));
    expect_dgram(0, 16'd5000, 16'd5001, 16'd11);
    compare_stream("t1");
    check("t1_done", 32'(done_q[0]), 32'h1);
    check("t1_err", 32'(err_q[0]), 32'h0);

    // T2: all four requesting, len 4; requester 0 sends twice
    do_reset();
    for (int r = 0; r < 4; r++)
      set_req(r, 16'h1000 + 16'(r), 16'h2000 + 16'(r), 16'd4, (r == 0) ? 2 : 1);
    run_done("t2", 5, 400);
    check("t2_grant_count", 32'(grant_q.size()), 32'd5);
    check("t2_grant0", 32'(grant_q[0]), 32'h1);
    check("t2_grant1", 32'(grant_q[1]), 32'h2);
    check("t2_grant2", 32'(grant_q[2]), 32'h4);
    check("t2_grant3", 32'(grant_q[3]), 32'h8);
    check("t2_grant4", 32'(grant_q[4]), 32'h1);
    check("t2_gap_count", 32'(gap_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_gap%0d", i), 32'(gap_q[i]), 32'd3);
    expect_dgram(0, 16'h1000, 16'h2000, 16'd4);
    expect_dgram(1, 16'h1001, 16'h2001, 16'd4);
    expect_dgram(2, 16'h1002, 16'h2002, 16'd4);
    expect_dgram(3, 16'h1003, 16'h2003, 16'd4);
    expect_dgram(0, 16'h1000, 16'h2000, 16'd4);
    compare_stream("t2");

    // T3: toggling udp_ready and in_valid gaps
    do_reset();
    ready_mode = 1;
    valid_mode = 1;
    set_req(1, 16'hABCD, 16'h0035, 16'd6, 1);
    run_done("t3", 1, 300);
    check("t3_stalls_seen", 32'(hold_cnt > 0), 32'h1);
    expect_dgram(1, 16'hABCD, 16'h0035, 16'd6);
    compare_stream("t3");
    ready_mode = 0;
    valid_mode = 0;

    // T4: dropped requests (len 0, len 1473) on requester 2
    do_reset();
    set_req(2, 16'h0202, 16'h0303, 16'd0, 1);
    step();
    check("t4_drop0", 32'({bus.done, bus.err_len, bus.grant, bus.udp_valid}), 32'({4'h4, 1'b1, 4'h0, 1'b0}));
    set_req(2, 16'h0202, 16'h0303, 16'd1473, 1);
    step();
    check("t4_no_repeat", 32'({bus.done, bus.err_len}), 32'h0);
    step();
    check("t4_drop1473", 32'({bus.done, bus.err_len, bus.grant, bus.udp_valid}), 32'({4'h4, 1'b1, 4'h0, 1'b0}));
    check("t4_no_valid", 32'(cap.size()), 32'd0);
    set_req(0, 16'h0101, 16'h0202, 16'd2, 1);
    set_req(3, 16'h0303, 16'h0404, 16'd2, 1);
    step();
    check("t4_ptr_at_3", 32'(bus.grant), 32'h8);
    run_done("t4", 2, 200);
    check("t4_grant_count", 32'(grant_q.size()), 32'd2);
    check("t4_grant1", 32'(grant_q[1]), 32'h1);
    expect_dgram(3, 16'h0303, 16'h0404, 16'd2);
    expect_dgram(0, 16'h0101, 16'h0202, 16'd2);
    compare_stream("t4");

    // T5: reset during payload byte 5, then clean restart
    do_reset();
    set_req(1, 16'h1111, 16'h2222, 16'd11, 1);
    left = 100;
    while (cap.size() < 13 && left > 0) begin
      step();
      left--;
    end
    check("t5_reached_byte5", 32'(cap.size()), 32'd13);
    rst = 1'b1;
    step();
    check("t5_rst_outputs", 32'(out_vec()), 32'h0);
    check("t5_no_done", 32'(done_q.size()), 32'd0);
    lasts = 0;
    foreach (cap_last[i]) lasts += int'(cap_last[i]);
    check("t5_no_last", 32'(lasts), 32'd0);
    rst = 1'b0;
    bus.req = '0;
    for (int r = 0; r < 4; r++) req_left[r] = 0;
    clear_mon();
    set_req(0, 16'h0A0B, 16'h0C0D, 16'd3, 1);
    step();
    check("t5_restart", 32'({bus.grant, bus.udp_valid, bus.udp_data}), 32'({4'h1, 1'b1, 8'h0A}));
    run_done("t5", 1, 100);
    expect_dgram(0, 16'h0A0B, 16'h0C0D, 16'd3);
    compare_stream("t5");

    // T6: length boundaries 1 and 1472
    clear_mon();
    set_req(0, 16'h0001, 16'h0002, 16'd1, 1);
    run_done("t6a", 1, 100);
    check("t6a_len_hi", 32'(cap[4]), 32'h00);
    check("t6a_len_lo", 32'(cap[5]), 32'h09);
    check("t6a_last", 32'({cap_last[7], cap_last[8]}), 32'h1);
    check("t6a_size", 32'(cap.size()), 32'd9);
    clear_mon();
    set_req(1, 16'h0003, 16'h0004, 16'd1472, 1);
    run_done("t6b", 1, 3000);
    check("t6b_len_hi", 32'(cap[4]), 32'h05);
    check("t6b_len_lo", 32'(cap[5]), 32'hC8);
    check("t6b_last", 32'({cap_last[1478], cap_last[1479]}), 32'h1);
    expect_dgram(1, 16'h0003, 16'h0004, 16'd1472);
    compare_stream("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
